// File: rtl/seq_sum_pkg.sv
// Shared definitions for the seq_sum_reader buffer.
//   WIDTH_DEFAULT / DEPTH_DEFAULT : default word width and buffer depth
//   fill_state_e                  : occupancy state of the buffer
package seq_sum_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } fill_state_e;

endpackage

// File: rtl/seq_sum_fifo_mem.sv
// DEPTH x WIDTH register array used as FIFO storage.
// Storage has no reset; the surrounding control logic guarantees that stale
// entries are never presented as valid.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data
module seq_sum_fifo_mem
  import seq_sum_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/seq_sum_reader.sv
// Consumer-side buffer for an enabled sum register. Words arrive over a
// valid/ready handshake, are held in a small FIFO, and are handed to a reader
// whose side is gated by en. A flush discards the buffered words and adds
// their number to a saturating drop counter.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_data    : producer word, accepted when in_ready is high
//   in_ready            : buffer not full
//   en                  : read enable; low stalls the output side
//   flush               : synchronous clear of buffered contents
//   out_valid/out_data  : head-of-buffer word, taken when out_ready is high
//   count               : current occupancy
//   drop_cnt            : words discarded by flush (saturating)
module seq_sum_reader
  import seq_sum_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic                       en,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  fill_state_e      state_q, state_d;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] rdata;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CW-1:0]    b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // The state register mirrors count, so handshake outputs decode it directly.
  assign in_ready  = (state_q != FULL);
  assign out_valid = en & (state_q != EMPTY);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Storage is not reset, so hold out_data at zero while nothing is buffered.
  assign out_data  = (state_q != EMPTY) ? rdata : '0;
  assign count     = count_q;
  assign drop_cnt  = drop_q;

  seq_sum_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    state_d  = state_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      drop_d   = sat_add(drop_q, count_q);
      state_d  = EMPTY;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);

      case (state_q)
        EMPTY: begin
          // pop cannot occur while empty
          if (push) state_d = PARTIAL;
        end
        PARTIAL: begin
          if (push && !pop && count_q == CW'(DEPTH - 1)) state_d = FULL;
          else if (pop && !push && count_q == CW'(1))    state_d = EMPTY;
        end
        FULL: begin
          // push is refused while full, so any pop leaves room
          if (pop) state_d = PARTIAL;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      state_q  <= EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_seq_sum_reader.sv
module tb_seq_sum_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             en;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [2:0]       count;
  logic [CNT_W-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sb[$];

  always #5 clk = ~clk;

  seq_sum_reader #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .en        (en),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  // Scoreboard: every output handshake is compared with the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && en && !flush) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: out_data=%h, required no output word", out_data);
      end else begin
        logic [WIDTH-1:0] exp;
        exp = sb.pop_front();
        if (out_data !== exp) begin
          errors++;
          $display("FAIL pop_data: out_data=%h, required %h", out_data, exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; en = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_held: out_valid=%b count=%0d out_data=%h, required 0 0 00",
               out_valid, count, out_data);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || drop_cnt !== 8'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: out_valid=%b count=%0d drop_cnt=%0d in_ready=%b, required 0 0 0 1",
               out_valid, count, drop_cnt, in_ready);
    end
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] v;
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v = 8'(17 * (i + 1));
      in_valid = 1'b1; in_data = v;
      sb.push_back(v);
      step();
      checks++;
      if (out_data !== v || count !== 3'd1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_word%0d: out_data=%h count=%0d out_valid=%b, required %h 1 1",
                 i, out_data, count, out_valid, v);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (count !== 3'd0 || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_drain: count=%0d pending=%0d, required 0 0", count, sb.size());
    end
  endtask

  task automatic test_full();
    en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
      sb.push_back(8'hA0 + 8'(i));
      step();
    end
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_state: count=%0d in_ready=%b out_valid=%b, required 4 0 0",
               count, in_ready, out_valid);
    end
    in_data = 8'hA4;
    step();
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL full_refuse: count=%0d, required 4", count);
    end
    en = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA0) begin
      errors++;
      $display("FAIL full_head: out_valid=%b out_data=%h, required 1 a0", out_valid, out_data);
    end
    for (int i = 0; i < 10 && count != 3'd0; i++) step();
    checks++;
    if (count !== 3'd0 || sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_drain: count=%0d pending=%0d out_valid=%b, required 0 0 0",
               count, sb.size(), out_valid);
    end
  endtask

  task automatic test_back_to_back();
    en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'hB0 + 8'(i);
      sb.push_back(8'hB0 + 8'(i));
      step();
    end
    checks++;
    if (count !== 3'd2) begin
      errors++;
      $display("FAIL b2b_fill: count=%0d, required 2", count);
    end
    out_ready = 1'b1;
    for (int i = 2; i < 4; i++) begin
      in_data = 8'hB0 + 8'(i);
      sb.push_back(8'hB0 + 8'(i));
      step();
      checks++;
      if (count !== 3'd2 || out_data !== 8'hB0 + 8'(i - 1)) begin
        errors++;
        $display("FAIL b2b_simul%0d: count=%0d out_data=%h, required 2 %h",
                 i, count, out_data, 8'hB0 + 8'(i - 1));
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && count != 3'd0; i++) step();
    checks++;
    if (count !== 3'd0 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: count=%0d pending=%0d, required 0 0", count, sb.size());
    end
  endtask

  task automatic test_wrap();
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'hE0 + 8'(i);
      sb.push_back(8'hE0 + 8'(i));
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && count != 3'd0; i++) step();
    checks++;
    if (count !== 3'd0 || sb.size() != 0) begin
      errors++;
      $display("FAIL wrap_drain: count=%0d pending=%0d, required 0 0", count, sb.size());
    end
  endtask

  task automatic test_flush();
    int exp_drop;
    int extra;
    en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'hC0 + 8'(i);
      step();
    end
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL flush_fill: count=%0d, required 3", count);
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (count !== 3'd0 || drop_cnt !== 8'd3 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_once: count=%0d drop_cnt=%0d in_ready=%b, required 0 3 1",
               count, drop_cnt, in_ready);
    end
    en = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_55: out_valid=%b out_data=%h, required out_valid 0",
               out_valid, out_data);
    end
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL flush_idle: out_valid=%b count=%0d, required 0 0", out_valid, count);
    end
    en = 1'b0;
    exp_drop = 3;
    extra = 0;
    for (int k = 0; k < 80 && extra < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        in_valid = 1'b1; in_data = 8'(k + i);
        step();
      end
      in_valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      exp_drop = (exp_drop + 4 > 255) ? 255 : exp_drop + 4;
      if (exp_drop == 255) extra++;
      checks++;
      if (drop_cnt !== 8'(exp_drop) || count !== 3'd0) begin
        errors++;
        $display("FAIL flush_sat%0d: drop_cnt=%0d count=%0d, required %0d 0",
                 k, drop_cnt, count, exp_drop);
      end
    end
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL flush_saturated: drop_cnt=%0d, required 255", drop_cnt);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'hD0 + 8'(i);
      sb.push_back(8'hD0 + 8'(i));
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd2 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_fill: count=%0d out_valid=%b, required 2 1", count, out_valid);
    end
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || drop_cnt !== 8'd0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL areset_immediate: count=%0d out_valid=%b drop_cnt=%0d out_data=%h, required 0 0 0 00",
               count, out_valid, drop_cnt, out_data);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_release: in_ready=%b count=%0d out_valid=%b, required 1 0 0",
               in_ready, count, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_full();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_sum_reader.md
Name: seq_sum_reader

Overview:
- Consumer-side counterpart to an enabled sum register: accepts 8-bit words from a producer over valid/ready, buffers them, and hands them to a downstream reader gated by an enable.
- Sits between a sum/accumulator register and its consumer; also serves as a sequential-inference benchmark with FIFO, counter and enable-gated read patterns.
- Tracks occupancy and counts words discarded by flush.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word.
- in_data  input  WIDTH  producer word.
- in_ready  output  1  buffer can accept; equals !full.
- en  input  1  read enable; when low, output side stalls.
- flush  input  1  synchronous clear of buffered contents.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  WIDTH  head-of-buffer word.
- out_ready  input  1  reader accepts word.
- count  output  $clog2(DEPTH+1)  current occupancy.
- drop_cnt  output  CNT_W  words discarded by flush, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): write ptr, read ptr, count, drop_cnt = 0; out_valid = 0; out_data = 0; storage contents are don't-care. in_ready = 1 once reset is released.
- push = in_valid & in_ready & !flush. pop = out_valid & out_ready & en & !flush.
- out_valid = en & (count != 0). out_data = head entry, registered storage with no fall-through. A word pushed at edge N is visible on out_data from cycle N+1.
- in_ready = (count != DEPTH). When full, push is refused even if pop occurs in the same cycle; no bypass.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- en low: out_valid = 0, no pop; pushes continue until full.
- flush high has priority over push and pop:
  - pointers and count clear next edge.
  - drop_cnt += count, saturating at 2^CNT_W-1.
  - in_data presented that cycle is not stored.
- drop_cnt is only cleared by reset.
- Reset asserted mid-transfer: all state clears immediately, and words in flight are lost without being counted in drop_cnt.
- Internal control FSM has three states:
  - EMPTY: count == 0.
  - PARTIAL: 0 < count < DEPTH.
  - FULL: count == DEPTH.
  - Transitions follow the push/pop/flush rules above; flush always goes to EMPTY. The state is registered alongside count, and the two must agree.

Decomposition:
- Package seq_sum_pkg holds WIDTH_DEFAULT = 8, DEPTH_DEFAULT = 4, and an enum typedef fill_state_e {EMPTY, PARTIAL, FULL}.
- One sub-module, seq_sum_fifo_mem: DEPTH x WIDTH register array with write port (we, waddr, wdata) and combinational read port (raddr, rdata), clocked by clk with no reset.
- Top level owns the pointers, count, FSM, drop counter and handshake logic.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles, then release -> out_valid = 0, count = 0, drop_cnt = 0, in_ready = 1.
- Streaming: en = 1, out_ready = 1, push 0x11, 0x22, 0x33 on consecutive cycles -> out_data = 0x11, 0x22, 0x33 on cycles 1, 2, 3 after each respective push; count never exceeds 1.
- Full: en = 0, push 0xA0..0xA4 -> first four accepted; in_ready = 0 on 5th attempt; count = 4. Then en = 1 with out_ready = 1 -> 0xA0..0xA3 drain in order; 0xA4 is never output.
- Simultaneous push/pop at count = 2 -> count stays 2, ordering preserved. Pointer wrap: push and pop 10 words -> output sequence identical to input.
- Flush: with count = 3, assert flush for one cycle while in_valid = 1 (in_data 0x55) -> next cycle count = 0, out_valid = 0, drop_cnt = 3, and 0x55 is absent. Repeat flushes until drop_cnt saturates at 255.
- Async reset: with count = 2, drop rst_n between clock edges -> out_valid = 0 and count = 0 before the next clk edge.
